// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared opcodes and occupancy states for the FIFO controller
package fifo_ctrl_pkg;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_RDWR  = 2'b11;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ACTIVE = 2'd1,
    S_FULL   = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - AW-bit wrapping pointer with increment enable and synchronous clear
module fifo_ptr
  import fifo_ctrl_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [AW-1:0] o_ptr
);

  logic [AW-1:0] r_ptr;

  // Natural overflow of the AW-bit register gives the modulo-2^AW wrap.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer, occupancy and flag sequencing that turns a two-port RAM into a FIFO
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int AW        = 3,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [AW-1:0] o_ram_addrw,
  output logic [AW-1:0] o_ram_addrr,
  output logic [1:0]    o_ram_rw,
  output logic          o_rd_valid,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_almost_full,
  output logic          o_almost_empty,
  output logic          o_overflow,
  output logic          o_underflow
);

  localparam int CW = AW + 1;
  localparam logic [AW:0] DEPTH = CW'(1 << AW);
  localparam logic [AW:0] AF_LVL = CW'(AF_THRESH);
  localparam logic [AW:0] AE_LVL = CW'(AE_THRESH);

  logic          w_pop_ok;
  logic          w_push_ok;
  logic          w_push_only;
  logic          w_pop_only;
  logic          w_empty;
  logic          w_full;
  logic [AW-1:0] w_wptr;
  logic [AW-1:0] w_rptr;
  logic [AW:0]   r_count;
  logic          r_rd_valid;
  logic          r_overflow;
  logic          r_underflow;
  state_e        r_state;
  state_e        w_state_nxt;

  // A push on full is only legal when the same-cycle pop frees the slot it overwrites.
  assign w_pop_ok    = i_pop & ~w_empty & ~i_flush;
  assign w_push_ok   = i_push & ~i_flush & (~w_full | w_pop_ok);
  assign w_push_only = w_push_ok & ~w_pop_ok;
  assign w_pop_only  = w_pop_ok & ~w_push_ok;

  fifo_ptr #(.AW(AW)) u_wptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_flush),
    .i_inc   (w_push_ok),
    .o_ptr   (w_wptr)
  );

  fifo_ptr #(.AW(AW)) u_rptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_flush),
    .i_inc   (w_pop_ok),
    .o_ptr   (w_rptr)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_flush) begin
        r_count <= '0;
      end else if (w_push_only) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop_only) begin
        r_count <= r_count - 1'b1;
      end
      r_rd_valid  <= w_pop_ok;
      r_overflow  <= i_push & ~w_push_ok & ~i_flush;
      r_underflow <= i_pop & ~w_pop_ok & ~i_flush;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push_only) w_state_nxt = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (w_push_only && (r_count == DEPTH - 1'b1)) w_state_nxt = S_FULL;
          else if (w_pop_only && (r_count == CW'(1))) w_state_nxt = S_EMPTY;
        end
        S_FULL: begin
          if (w_pop_only) w_state_nxt = S_ACTIVE;
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_empty = 1'b0;
    w_full  = 1'b0;
    case (r_state)
      S_EMPTY: w_empty = 1'b1;
      S_FULL:  w_full  = 1'b1;
      default: begin
        w_empty = 1'b0;
        w_full  = 1'b0;
      end
    endcase
  end

  // Reset gates the command asynchronously so the RAM sees idle before its own sync reset lands.
  assign o_ram_rw       = i_reset ? {w_pop_ok, w_push_ok} : RW_IDLE;
  assign o_ram_addrw    = w_wptr;
  assign o_ram_addrr    = w_rptr;
  assign o_rd_valid     = r_rd_valid;
  assign o_count        = r_count;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= AF_LVL);
  assign o_almost_empty = (r_count <= AE_LVL);
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Sequencing controller that turns the team's two-port RAM (separate read and write addresses, 2-bit `rw` opcode, 1-cycle registered read) into a synchronous FIFO. It owns the read/write pointers, occupancy count and status flags, and it issues `rw`/`addrr`/`addrw` every cycle. Data does not pass through this block: `data_in` goes straight to the RAM, and the RAM's `data_out_c` is qualified by `rd_valid`. It sits between producer/consumer logic and the RAM in the buffering path.

## Interface
- `AW`, 3: RAM address width; FIFO depth is 2^AW.
- `AF_THRESH`, 6: `almost_full` asserts when count >= AF_THRESH.
- `AE_THRESH`, 1: `almost_empty` asserts when count <= AE_THRESH.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `push` in 1: write request; RAM takes `data_in` this cycle.
- `pop` in 1: read request.
- `flush` in 1: synchronous clear of FIFO state.
- `ram_addrw` out AW: RAM write address (= write pointer).
- `ram_addrr` out AW: RAM read address (= read pointer).
- `ram_rw` out 2: 00 idle, 01 write, 10 read, 11 read+write.
- `rd_valid` out 1: RAM `data_out_c` holds popped word.
- `count` out AW+1: occupancy, 0..2^AW.
- `full`, `empty`, `almost_full`, `almost_empty` out 1 each: status flags.
- `overflow`, `underflow` out 1 each: 1-cycle pulse on a rejected request.

## Operation
- Accept rules:
  - pop_ok = pop & !empty & !flush.
  - push_ok = push & !flush & (!full | pop_ok). Push is accepted on full only when a pop is accepted in the same cycle.
- `ram_rw` = {pop_ok, push_ok}, combinational. It is forced to 00 while `reset` is low or `flush` is high.
- `ram_addrw`/`ram_addrr` are the pointer registers, driven combinationally.
- Pointers increment by 1 on their own accept and wrap modulo 2^AW (7 -> 0 for AW=3).
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or on neither.
- Full, simultaneous push+pop: the pointers are equal. The RAM returns the old word and writes the new one, which is the required behaviour.
- Empty, simultaneous push+pop: only the push is accepted, and `underflow` pulses.
- `overflow` pulses on push & !push_ok & !flush. `underflow` pulses on pop & !pop_ok & !flush. Both are registered.
- Occupancy FSM has three states:
  - S_EMPTY -> S_ACTIVE on push-only.
  - S_ACTIVE -> S_FULL when a push-only brings count to 2^AW.
  - S_ACTIVE -> S_EMPTY when a pop-only brings count to 0.
  - S_FULL -> S_ACTIVE on pop-only.
  - Any state -> S_EMPTY on `flush`.
- Flag decode: `empty` = S_EMPTY, `full` = S_FULL. `almost_*` compare `count` against the thresholds.
- `flush`: pointers, count and FSM return to their reset values on the next edge. `rd_valid` is 0 on the next cycle. RAM contents are untouched and considered stale.
- Reset, with `reset` low and independent of `clk`:
  - Pointers 0, count 0, S_EMPTY.
  - `empty`=1, `almost_empty`=1.
  - `full`, `almost_full`, `rd_valid`, `overflow`, `underflow` = 0; `ram_rw`=00.
- Reset mid-burst drops any in-flight read immediately: `rd_valid` goes to 0.

## Timing
- Request to RAM command: 0 cycles (combinational).
- Pop to data: `rd_valid` is a register of pop_ok. It asserts in the cycle after the accepted pop, aligned with RAM `data_out_c`.
- Flags, count and error pulses update on the edge that ends the request cycle.
- Write-then-read: push at cycle t and pop at t+1 is legal. The t+1 pop reads the word written at edge t.
- Back-to-back pops give `rd_valid` high on consecutive cycles, one word each.

## Structure
- Shared package `fifo_ctrl_pkg`:
  - RW opcodes: RW_IDLE=2'b00, RW_WRITE=2'b01, RW_READ=2'b10, RW_RDWR=2'b11.
  - FSM state encoding: S_EMPTY, S_ACTIVE, S_FULL.
- Sub-module `fifo_ptr`: AW-bit wrapping pointer with increment enable and synchronous clear. It is instantiated twice, once for the write pointer and once for the read pointer.
- The bench uses a wrapper that instantiates `fifo_ctrl` with the two-port RAM. Note that the RAM's own reset is synchronous, so hold `reset` low for at least 2 `clk` cycles.

## Test plan
All scenarios use AW=3, AF_THRESH=6, AE_THRESH=1.
- **Reset:** `reset` low mid-cycle -> immediately `empty`=1, `almost_empty`=1, `count`=0, `ram_rw`=00, `rd_valid`=0.
- **Fill to full:** push 1..8 on consecutive cycles -> `ram_addrw` 0..7 with `ram_rw`=01; `almost_full` after the 6th; `full`=1, `count`=8 after the 8th. A 9th push -> `ram_rw`=00, `overflow` pulse, `count` stays 8.
- **Drain:** pop 8 times -> `ram_addrr` 0..7; `rd_valid` one cycle later each time with data 1..8; `empty`=1 after the last. A 9th pop -> `ram_rw`=00, `underflow` pulse.
- **Simultaneous push+pop:**
  - At count=3 -> `ram_rw`=11, `count` stays 3.
  - At full -> both accepted, and the returned word is the oldest.
  - At empty -> `ram_rw`=01, `underflow` pulse, `count`=1.
- **Wrap-around:** run 12 push/pop pairs -> pointers wrap 7 -> 0 and data order is preserved.
- **Flush:** at count=5 with `push`=1 -> `ram_rw`=00 that cycle; next cycle `count`=0, `empty`=1, pointers 0, `rd_valid`=0.
